// File: rtl/stack_unit.sv
// stack_unit: operand stack for the multicycle stack processor.
// Answers the controller's push/pop/tos strobes, returns the top entry on a
// registered dout, tracks depth and keeps sticky overflow/underflow flags.
module stack_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,      // asynchronous, active-low
  input  logic              push,
  input  logic              pop,
  input  logic              tos,
  input  logic [DATA_W-1:0] din,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              ovf,
  output logic              udf
);

  localparam int DEPTH = 1 << ADDR_W;

  // Storage carries no reset; its contents before the first push are don't-care.
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W:0]   sp_reg,   sp_next;
  logic [DATA_W-1:0] dout_reg, dout_next;
  logic              ovf_reg,  ovf_next;
  logic              udf_reg,  udf_next;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] top_addr;
  logic [DATA_W-1:0] rd_data;
  logic              ovf_set;
  logic              udf_set;
  logic              is_empty;
  logic              is_full;

  // sp only ever reaches 2**ADDR_W, so its MSB alone marks a full stack.
  // When full the low bits are zero and the decrement wraps to DEPTH-1,
  // which is exactly the top slot.
  assign is_empty = (sp_reg == '0);
  assign is_full  = sp_reg[ADDR_W];
  assign top_addr = sp_reg[ADDR_W-1:0] - 1'b1;
  assign rd_data  = mem[top_addr];

  // Command decode in priority order: push&pop, push, pop, tos.
  always_comb begin
    sp_next   = sp_reg;
    dout_next = dout_reg;
    we        = 1'b0;
    waddr     = sp_reg[ADDR_W-1:0];
    ovf_set   = 1'b0;
    udf_set   = 1'b0;
    if (push && pop) begin
      if (!is_empty) begin
        // Replace the top entry in place; legal even when full.
        we        = 1'b1;
        waddr     = top_addr;
        dout_next = din;
      end else begin
        udf_set = 1'b1;
      end
    end else if (push) begin
      if (!is_full) begin
        we        = 1'b1;
        sp_next   = sp_reg + 1'b1;
        dout_next = din;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (pop) begin
      if (!is_empty) begin
        dout_next = rd_data;
        sp_next   = sp_reg - 1'b1;
      end else begin
        udf_set = 1'b1;
      end
    end else if (tos) begin
      if (!is_empty) begin
        dout_next = rd_data;
      end else begin
        udf_set = 1'b1;
      end
    end
    // A new error event outranks a clear in the same cycle.
    ovf_next = ovf_set ? 1'b1 : (err_clr ? 1'b0 : ovf_reg);
    udf_next = udf_set ? 1'b1 : (err_clr ? 1'b0 : udf_reg);
  end

  // Storage write; gated by reset so a command seen during reset never lands.
  always_ff @(posedge clk) begin
    if (rst && we) begin
      mem[waddr] <= din;
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp_reg   <= '0;
      dout_reg <= '0;
      ovf_reg  <= 1'b0;
      udf_reg  <= 1'b0;
    end else begin
      sp_reg   <= sp_next;
      dout_reg <= dout_next;
      ovf_reg  <= ovf_next;
      udf_reg  <= udf_next;
    end
  end

  assign dout  = dout_reg;
  assign count = sp_reg;
  assign empty = is_empty;
  assign full  = is_full;
  assign ovf   = ovf_reg;
  assign udf   = udf_reg;

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: vector table, hand-written reset sequences and a randomized
// run against a queue-based model of the stack, for a 4-deep 8-bit instance.
module tb_stack_unit;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic          push;
  logic          pop;
  logic          tos;
  logic [DW-1:0] din;
  logic          err_clr;
  logic [DW-1:0] dout;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          ovf;
  logic          udf;

  int total;
  int bad;

  stack_unit #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .tos     (tos),
    .din     (din),
    .err_clr (err_clr),
    .dout    (dout),
    .count   (count),
    .empty   (empty),
    .full    (full),
    .ovf     (ovf),
    .udf     (udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          push;
    logic          pop;
    logic          tos;
    logic          err_clr;
    logic [DW-1:0] din;
    logic [DW-1:0] e_dout;
    int            e_count;
    logic          e_empty;
    logic          e_full;
    logic          e_ovf;
    logic          e_udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic p, input logic po, input logic t,
                              input logic e, input logic [DW-1:0] d,
                              input logic [DW-1:0] ed, input int ec,
                              input logic eo, input logic eu);
    vec_t v;
    v.push = p; v.pop = po; v.tos = t; v.err_clr = e; v.din = d;
    v.e_dout = ed; v.e_count = ec;
    v.e_empty = (ec == 0);
    v.e_full  = (ec == DEPTH);
    v.e_ovf = eo; v.e_udf = eu;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [DW-1:0] ed, input int ec,
                         input logic ee, input logic ef, input logic eo, input logic eu);
    chk({tag, ".dout"},  int'(dout),  int'(ed));
    chk({tag, ".count"}, int'(count), ec);
    chk({tag, ".empty"}, int'(empty), int'(ee));
    chk({tag, ".full"},  int'(full),  int'(ef));
    chk({tag, ".ovf"},   int'(ovf),   int'(eo));
    chk({tag, ".udf"},   int'(udf),   int'(eu));
  endtask

  // Drive one command just after an edge, clock it in, sample 1 ns later.
  task automatic apply(input logic p, input logic po, input logic t,
                       input logic e, input logic [DW-1:0] d);
    push = p; pop = po; tos = t; err_clr = e; din = d;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; tos = 1'b0; err_clr = 1'b0;
  endtask

  // Reference model state.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_ovf;
  logic          m_udf;

  task automatic model_step(input logic p, input logic po, input logic t,
                            input logic e, input logic [DW-1:0] d);
    logic so, su;
    so = 1'b0; su = 1'b0;
    if (p && po) begin
      if (q.size() > 0) begin q[q.size()-1] = d; m_dout = d; end
      else su = 1'b1;
    end else if (p) begin
      if (q.size() < DEPTH) begin q.push_back(d); m_dout = d; end
      else so = 1'b1;
    end else if (po) begin
      if (q.size() > 0) m_dout = q.pop_back();
      else su = 1'b1;
    end else if (t) begin
      if (q.size() > 0) m_dout = q[q.size()-1];
      else su = 1'b1;
    end
    m_ovf = so ? 1'b1 : (e ? 1'b0 : m_ovf);
    m_udf = su ? 1'b1 : (e ? 1'b0 : m_udf);
  endtask

  initial begin
    total = 0; bad = 0;
    push = 0; pop = 0; tos = 0; err_clr = 0; din = '0;

    // Power-on reset: low for 50 ns, then check reset values.
    rst = 1'b0;
    #50;
    rst = 1'b1;
    #1;
    chk_all("reset", 8'h00, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("reset: dout=%h count=%0d empty=%0b full=%0b ovf=%0b udf=%0b",
             dout, count, empty, full, ovf, udf);
    @(posedge clk);
    #1;

    //            push pop tos clr din    dout  cnt ovf udf
    // push then read back
    vecs.push_back(mk(1, 0, 0, 0, 8'h11, 8'h11, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'h22, 8'h22, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'h33, 8'h33, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h33, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h33, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h22, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h11, 0, 0, 0));
    // overflow
    vecs.push_back(mk(1, 0, 0, 0, 8'h01, 8'h01, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'h02, 8'h02, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'h03, 8'h03, 3, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'h04, 8'h04, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'h05, 8'h04, 4, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h04, 3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h03, 2, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h02, 1, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h01, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h01, 0, 0, 0));
    // underflow and clear, set wins over clear
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h01, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h01, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h01, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 8'h01, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h01, 0, 0, 0));
    // simultaneous push & pop
    vecs.push_back(mk(1, 0, 0, 0, 8'hA0, 8'hA0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'hB0, 8'hB0, 2, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 8'hCC, 8'hCC, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'hCC, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'hA0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 8'hEE, 8'hA0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'hA0, 0, 0, 0));
    // push & pop while full is a legal replace
    vecs.push_back(mk(1, 0, 0, 0, 8'h01, 8'h01, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'h02, 8'h02, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'h03, 8'h03, 3, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'h04, 8'h04, 4, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 8'h09, 8'h09, 4, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h09, 4, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h09, 3, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h03, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h02, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 8'h00, 8'h01, 0, 0, 0));
    // tos is ignored alongside push or pop
    vecs.push_back(mk(1, 0, 1, 0, 8'h5A, 8'h5A, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 8'h00, 8'h5A, 0, 0, 0));

    foreach (vecs[i]) begin
      apply(vecs[i].push, vecs[i].pop, vecs[i].tos, vecs[i].err_clr, vecs[i].din);
      chk_all($sformatf("vec%0d", i), vecs[i].e_dout, vecs[i].e_count,
              vecs[i].e_empty, vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_udf);
      $display("vec %0d: push=%0b pop=%0b tos=%0b clr=%0b din=%h -> dout=%h count=%0d ovf=%0b udf=%0b",
               i, vecs[i].push, vecs[i].pop, vecs[i].tos, vecs[i].err_clr,
               vecs[i].din, dout, count, ovf, udf);
    end

    // Reset mid-sequence: asynchronous clear, commands ignored while low.
    apply(1, 0, 0, 0, 8'h55);
    apply(1, 0, 0, 0, 8'h66);
    chk("mid.pre_count", int'(count), 2);
    push = 1'b1; din = 8'h77;
    #3;
    rst = 1'b0;
    #1;
    chk("mid.async_count", int'(count), 0);
    chk("mid.async_dout", int'(dout), 0);
    chk("mid.async_empty", int'(empty), 1);
    @(posedge clk);
    #1;
    chk("mid.held_count", int'(count), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    push = 1'b0;
    chk("mid.post_count", int'(count), 1);
    chk("mid.post_dout", int'(dout), 8'h77);
    apply(0, 0, 1, 0, 8'h00);
    chk("mid.tos_dout", int'(dout), 8'h77);
    chk("mid.tos_count", int'(count), 1);
    $display("reset-mid: count=%0d dout=%h", count, dout);

    // Randomized run against the queue model.
    rst = 1'b0;
    #3;
    rst = 1'b1;
    q.delete();
    m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    @(posedge clk);
    #1;
    for (int n = 0; n < 400; n++) begin
      logic p, po, t, e;
      logic [DW-1:0] d;
      p  = ($urandom_range(0, 99) < 45);
      po = ($urandom_range(0, 99) < 40);
      t  = ($urandom_range(0, 99) < 25);
      e  = ($urandom_range(0, 99) < 10);
      d  = DW'($urandom);
      apply(p, po, t, e, d);
      model_step(p, po, t, e, d);
      chk_all($sformatf("rnd%0d", n), m_dout, q.size(), q.size() == 0,
              q.size() == DEPTH, m_ovf, m_udf);
      $display("rnd %0d: push=%0b pop=%0b tos=%0b clr=%0b din=%h -> dout=%h count=%0d ovf=%0b udf=%0b",
               n, p, po, t, e, d, dout, count, ovf, udf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
# stack_unit

Hardware operand stack for the multicycle stack processor: the responder to the controller's push/pop/tos strobes. It stores operands pushed from the datapath and returns the top entry on pop or tos. It tracks depth, and it raises sticky overflow and underflow flags. It sits between the controller's stack strobes and the datapath's A/B operand registers.

## Interface

Parameters:
- DATA_W, 8, operand width in bits
- ADDR_W, 4, pointer width; the stack depth is 2**ADDR_W entries

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset; low clears all state immediately, independent of clk
- push  in  1  write din as the new top entry
- pop  in  1  read the top entry to dout and remove it
- tos  in  1  read the top entry to dout without removing it
- din  in  DATA_W  push data from the datapath
- err_clr  in  1  clear the ovf and udf flags
- dout  out  DATA_W  registered read data
- count  out  ADDR_W+1  number of valid entries, 0..2**ADDR_W
- empty  out  1  count == 0
- full  out  1  count == 2**ADDR_W
- ovf  out  1  sticky: a push was attempted while full
- udf  out  1  sticky: a pop or tos was attempted while empty

## Operation

- Storage is 2**ADDR_W words of DATA_W bits, indexed 0 (bottom) upward.
- The storage array has no reset and its contents are don't-care. All other state is reset.
- Registered state is sp (= count), dout, ovf and udf. empty and full decode combinationally from the registered count.
- Commands are evaluated at each rising edge, in priority order:
  - push & pop, not empty: replace the top entry. mem[sp-1] <= din, dout <= din, sp unchanged. This case is legal when full.
  - push & pop, empty: no storage or sp change, dout held, udf <= 1.
  - push alone, not full: mem[sp] <= din, sp <= sp+1, dout <= din.
  - push alone, full: all state unchanged except ovf <= 1.
  - pop alone, not empty: dout <= mem[sp-1], sp <= sp-1.
  - pop alone, empty: dout and sp held, udf <= 1.
  - tos alone, not empty: dout <= mem[sp-1], sp unchanged.
  - tos alone, empty: dout held, udf <= 1.
  - none asserted: hold all state.
- tos is ignored whenever push or pop is asserted in the same cycle.
- No wrap-around: sp saturates at 0 and at 2**ADDR_W, and overflow or underflow never corrupts storage.
- err_clr clears ovf and udf. If an error event occurs in the same cycle, the set wins.
- Reset values: dout = 0, count = 0, empty = 1, full = 0, ovf = 0, udf = 0.

## Timing

- Read latency is 1 cycle: dout is valid immediately after the edge that samples pop or tos, and holds until the next read or push.
- count, empty and full update on the same edge as the command.
- Back-to-back commands are supported every cycle with no bubble.
- Read-after-write: a push at edge n followed by a tos at edge n+1 returns the pushed din.
- The controller deasserts strobes between states. A strobe held for k cycles is k operations, so a pop held 2 cycles removes 2 entries.
- Reset asserted mid-operation:
  - All registers clear asynchronously.
  - Any command sampled while rst is low is ignored.
  - The first command is accepted at the first rising edge after rst deasserts.

## Test plan

1. Reset, then check outputs. Stimulus: rst low 50 ns, then high. Required: dout = 0, count = 0, empty = 1, full = 0, ovf = 0, udf = 0.
2. Push and read back (ADDR_W = 2). Stimulus: push 0x11, 0x22, 0x33, then tos, pop, pop, pop. Required:
   - tos gives dout = 0x33 and count = 3.
   - The pops give dout = 0x33, 0x22, 0x11 and count = 2, 1, 0.
   - empty = 1 at the end.
3. Overflow (ADDR_W = 2). Stimulus: push 0x01..0x04, then push 0x05, then pop. Required:
   - After four pushes, full = 1 and count = 4.
   - The fifth push sets ovf = 1 and leaves count = 4.
   - The pop returns 0x04, not 0x05.
4. Underflow and clear. Stimulus: pop on an empty stack, then tos, then err_clr, then tos together with err_clr. Required:
   - The pop sets udf = 1 and holds dout.
   - udf stays 1 through the tos and clears to 0 after err_clr.
   - udf = 1 again after the simultaneous tos and err_clr, because the set wins.
5. Simultaneous push & pop. Stimulus: push 0xA0, 0xB0, then push & pop with din = 0xCC, then pop, pop. Required:
   - The push & pop leaves count = 2 and dout = 0xCC.
   - The pops return 0xCC, then 0xA0.
6. Reset mid-sequence. Stimulus: push 0x55, 0x66; drive rst low between clock edges with push = 1, din = 0x77; release rst. Required:
   - count = 0 and dout = 0 immediately, before the next clk edge.
   - The first push after release gives count = 1, and a following tos returns 0x77 only if din was 0x77 at that post-release push.
